other_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational two's-complement/zero helper in the ALU datapath.
- Single-operand ("other") operations on a data_width-bit signed word: negate, zero, absolute value, bitwise NOT, saturating negate, increment and decrement.
- Each result carries a per-result overflow flag. A sticky overflow status bit collects overflow events.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the ALU operand mux and the writeback mux.

---
 rtl/other_unit_pipe.sv | 102 ++++++++++
 tb/tb_other_unit_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/other_unit_pipe.sv
// other_unit_pipe: two-stage pipelined single-operand ALU ops (negate, zero, abs, not, sat-negate, inc, dec)
// with per-result overflow, reserved-op flag and a sticky overflow status bit.
module other_unit_pipe #(
    parameter int data_width = 16,
    parameter int op_width = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_a,
    input  logic [op_width-1:0]   in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_c,
    output logic                  out_ovf,
    output logic                  out_illegal,
    output logic                  ovf_sticky,
    input  logic                  clr_sticky
);
    localparam logic [data_width-1:0] min_v = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [data_width-1:0] max_v = ~min_v;
    localparam logic [data_width-1:0] one_v = 1;
    localparam logic [op_width-1:0] op_tcp  = op_width'(0);
    localparam logic [op_width-1:0] op_zero = op_width'(1);
    localparam logic [op_width-1:0] op_abs  = op_width'(2);
    localparam logic [op_width-1:0] op_not  = op_width'(3);
    localparam logic [op_width-1:0] op_sat  = op_width'(4);
    localparam logic [op_width-1:0] op_inc  = op_width'(5);
    localparam logic [op_width-1:0] op_dec  = op_width'(6);

    logic                  s1_valid_q, s1_valid_d;
    logic [data_width-1:0] s1_a_q, s1_a_d;
    logic [op_width-1:0]   s1_op_q, s1_op_d;
    logic                  out_valid_q, out_valid_d;
    logic [data_width-1:0] out_c_q, out_c_d;
    logic                  out_ovf_q, out_ovf_d;
    logic                  out_illegal_q, out_illegal_d;
    logic                  sticky_q, sticky_d;
    logic                  s2_load, accept, take, a_min, a_max, res_ovf, res_ill;
    logic [data_width-1:0] neg, res;

    always_comb begin
        s2_load = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;
        accept = in_valid && in_ready;
        take = s2_load && s1_valid_q;
        neg = ~s1_a_q + one_v;
        a_min = s1_a_q == min_v;
        a_max = s1_a_q == max_v;
        res = '0;
        res_ovf = 1'b0;
        res_ill = 1'b0;
        case (s1_op_q)
            op_tcp:  begin res = neg; res_ovf = a_min; end
            op_zero: res = '0;
            op_abs:  begin res = s1_a_q[data_width-1] ? neg : s1_a_q; res_ovf = a_min; end
            op_not:  res = ~s1_a_q;
            op_sat:  begin res = a_min ? max_v : neg; res_ovf = a_min; end
            op_inc:  begin res = s1_a_q + one_v; res_ovf = a_max; end
            op_dec:  begin res = s1_a_q - one_v; res_ovf = a_min; end
            default: res_ill = 1'b1;
        endcase
        s1_valid_d = accept || (s1_valid_q && !s2_load);
        s1_a_d = accept ? in_a : s1_a_q;
        s1_op_d = accept ? in_op : s1_op_q;
        out_valid_d = s2_load ? s1_valid_q : out_valid_q;
        out_c_d = take ? res : out_c_q;
        out_ovf_d = take ? res_ovf : out_ovf_q;
        out_illegal_d = take ? res_ill : out_illegal_q;
        // only a taken overflow result counts; a same-cycle clear loses to it
        sticky_d = (out_valid_q && out_ready && out_ovf_q) || (sticky_q && !clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q <= '0;
            s1_op_q <= '0;
            out_valid_q <= 1'b0;
            out_c_q <= '0;
            out_ovf_q <= 1'b0;
            out_illegal_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q <= s1_a_d;
            s1_op_q <= s1_op_d;
            out_valid_q <= out_valid_d;
            out_c_q <= out_c_d;
            out_ovf_q <= out_ovf_d;
            out_illegal_q <= out_illegal_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_c = out_c_q;
    assign out_ovf = out_ovf_q;
    assign out_illegal = out_illegal_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_other_unit_pipe.sv
// tb_other_unit_pipe: directed table, corner sequences and random traffic against 16- and 8-bit instances.
module tb_other_unit_pipe;
    logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, clr_sticky = 0;
    logic [15:0] in_a = '0;
    logic [2:0] in_op = '0;
    logic ir16, ov16, ovf16, ill16, st16, ir8, ov8, ovf8, ill8, st8;
    logic [15:0] c16;
    logic [7:0] c8;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    other_unit_pipe #(.data_width(16), .op_width(3)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir16), .in_a(in_a), .in_op(in_op),
        .out_valid(ov16), .out_ready(out_ready), .out_c(c16), .out_ovf(ovf16), .out_illegal(ill16),
        .ovf_sticky(st16), .clr_sticky(clr_sticky));

    other_unit_pipe #(.data_width(8), .op_width(3)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir8), .in_a(in_a[7:0]), .in_op(in_op),
        .out_valid(ov8), .out_ready(out_ready), .out_c(c8), .out_ovf(ovf8), .out_illegal(ill8),
        .ovf_sticky(st8), .clr_sticky(clr_sticky));

    typedef struct packed {logic [15:0] c; logic ovf; logic ill;} res_t;
    typedef struct packed {
        logic [2:0] op; logic [15:0] a; logic [15:0] c16; logic o16;
        logic [7:0] c8; logic o8; logic ill; logic s16; logic s8;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference: signed integer arithmetic, overflow = result outside the representable range
    function automatic res_t model(input int w, input logic [2:0] op, input logic [15:0] a);
        longint m = (longint'(1) << w) - 1;
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -hi - 1;
        longint s = longint'(a) & m;
        longint r;
        res_t o;
        if (s > hi) s = s - (m + 1);
        o.ill = 1'b0;
        case (op)
            3'd0: r = -s;
            3'd1: r = 0;
            3'd2: r = (s < 0) ? -s : s;
            3'd3: r = -s - 1;
            3'd4: r = -s;
            3'd5: r = s + 1;
            3'd6: r = s - 1;
            default: begin r = 0; o.ill = 1'b1; end
        endcase
        o.ovf = (r > hi) || (r < lo);
        if (op == 3'd4 && r > hi) r = hi;
        o.c = 16'(r & m);
        return o;
    endfunction

    res_t q16[$], q8[$];
    res_t h16, h8;
    logic sx16 = 0, sx8 = 0, t16, t8;

    // scoreboard: every transfer must match the oldest accepted operand, sticky tracked independently
    always @(negedge clk) begin
        if (reset) begin
            q16.delete();
            q8.delete();
            sx16 <= 1'b0;
            sx8 <= 1'b0;
        end else begin
            t16 = 1'b0;
            t8 = 1'b0;
            chk("mon_ready16", ir16, (q16.size() < 2) || out_ready);
            chk("mon_ready8", ir8, (q8.size() < 2) || out_ready);
            chk("mon_sticky16", st16, sx16);
            chk("mon_sticky8", st8, sx8);
            if (ov16 && out_ready) begin
                if (q16.size() == 0) chk("mon_extra16", 1, 0);
                else begin
                    h16 = q16.pop_front();
                    chk("mon_c16", c16, h16.c);
                    chk("mon_ovf16", ovf16, h16.ovf);
                    chk("mon_ill16", ill16, h16.ill);
                    t16 = h16.ovf;
                end
            end
            if (ov8 && out_ready) begin
                if (q8.size() == 0) chk("mon_extra8", 1, 0);
                else begin
                    h8 = q8.pop_front();
                    chk("mon_c8", c8, h8.c);
                    chk("mon_ovf8", ovf8, h8.ovf);
                    chk("mon_ill8", ill8, h8.ill);
                    t8 = h8.ovf;
                end
            end
            if (in_valid && ir16) q16.push_back(model(16, in_op, in_a));
            if (in_valid && ir8) q8.push_back(model(8, in_op, in_a));
            sx16 <= t16 || (sx16 && !clr_sticky);
            sx8 <= t8 || (sx8 && !clr_sticky);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input vec_t v, input string nm);
        out_ready = 1;
        in_valid = 1;
        in_op = v.op;
        in_a = v.a;
        step;
        in_valid = 0;
        chk({nm, "_lat1"}, ov16, 0);
        step;
        chk({nm, "_v16"}, ov16, 1);
        chk({nm, "_v8"}, ov8, 1);
        chk({nm, "_c16"}, c16, v.c16);
        chk({nm, "_o16"}, ovf16, v.o16);
        chk({nm, "_c8"}, c8, v.c8);
        chk({nm, "_o8"}, ovf8, v.o8);
        chk({nm, "_ill16"}, ill16, v.ill);
        chk({nm, "_ill8"}, ill8, v.ill);
        step;
        chk({nm, "_st16"}, st16, v.s16);
        chk({nm, "_st8"}, st8, v.s8);
    endtask

    vec_t tbl[15];
    logic [15:0] got[$];
    int n;

    initial begin
        tbl[0]  = '{3'd0, 16'h0005, 16'hFFFB, 1'b0, 8'hFB, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 16'h0005, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'd2, 16'hFFFB, 16'h0005, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd3, 16'h00FF, 16'hFF00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd0, 16'h8000, 16'h8000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'd2, 16'h8000, 16'h8000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'd4, 16'h8000, 16'h7FFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{3'd6, 16'h8000, 16'h7FFF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{3'd5, 16'h7FFF, 16'h8000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3'd0, 16'h0080, 16'hFF80, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{3'd4, 16'h0080, 16'hFF80, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{3'd5, 16'h007F, 16'h0080, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{3'd6, 16'h0080, 16'h007F, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{3'd2, 16'h0080, 16'h0080, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{3'd7, 16'h1234, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};

        step;
        step;
        reset = 0;
        chk("rst_valid16", ov16, 0);
        chk("rst_valid8", ov8, 0);
        chk("rst_c16", c16, 0);
        chk("rst_c8", c8, 0);
        chk("rst_ovf", ovf16, 0);
        chk("rst_ill", ill16, 0);
        chk("rst_sticky", st16, 0);
        chk("rst_ready16", ir16, 1);
        chk("rst_ready8", ir8, 1);

        for (int i = 0; i < 15; i++) run1(tbl[i], $sformatf("vec%0d", i));

        clr_sticky = 1;
        step;
        clr_sticky = 0;
        chk("clr_alone16", st16, 0);
        chk("clr_alone8", st8, 0);

        out_ready = 0;
        in_valid = 1;
        in_op = 3'd0;
        in_a = 16'h8000;
        step;
        in_valid = 0;
        step;
        step;
        step;
        chk("stall_valid", ov16, 1);
        chk("stall_no_sticky", st16, 0);
        out_ready = 1;
        step;
        chk("stall_taken_sticky", st16, 1);

        clr_sticky = 1;
        step;
        clr_sticky = 0;
        chk("clr_again", st16, 0);
        out_ready = 0;
        in_valid = 1;
        in_a = 16'h8000;
        step;
        in_valid = 0;
        step;
        clr_sticky = 1;
        out_ready = 1;
        step;
        clr_sticky = 0;
        chk("clr_with_ovf16", st16, 1);
        chk("clr_with_ovf8", st8, 0);

        out_ready = 0;
        in_valid = 1;
        in_op = 3'd0;
        n = 1;
        for (int k = 0; k < 6; k++) begin
            in_a = 16'(n);
            #1;
            if (ir16) n++;
            if (ov16) chk("bp_hold", c16, 16'hFFFF);
            step;
        end
        chk("bp_accepted", n - 1, 2);
        chk("bp_ready_low", ir16, 0);
        out_ready = 1;
        got.delete();
        for (int k = 0; k < 12; k++) begin
            in_valid = n <= 5;
            in_a = 16'(n);
            #1;
            if (ov16) got.push_back(c16);
            if (in_valid && ir16) n++;
            step;
        end
        in_valid = 0;
        chk("bp_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("bp_order%0d", i), got[i], 16'hFFFF - 16'(i));

        got.delete();
        in_op = 3'd5;
        for (int k = 0; k < 18; k++) begin
            in_valid = k < 16;
            in_a = 16'(k);
            #1;
            if (k < 16) chk("tp_ready", ir16, 1);
            chk("tp_valid", ov16, k >= 2);
            if (ov16) got.push_back(c16);
            step;
        end
        in_valid = 0;
        chk("tp_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk($sformatf("tp_res%0d", i), got[i], 16'(i + 1));

        run1(tbl[4], "pre_rst");
        out_ready = 0;
        in_valid = 1;
        in_op = 3'd0;
        in_a = 16'h0003;
        step;
        in_a = 16'h0004;
        step;
        in_valid = 0;
        chk("inflight_valid", ov16, 1);
        chk("inflight_sticky", st16, 1);
        reset = 1;
        step;
        reset = 0;
        chk("midrst_valid16", ov16, 0);
        chk("midrst_valid8", ov8, 0);
        chk("midrst_sticky", st16, 0);
        chk("midrst_c", c16, 0);
        chk("midrst_ready", ir16, 1);
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            step;
            chk("midrst_discard", ov16, 0);
        end
        run1('{3'd0, 16'h0001, 16'hFFFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}, "post_rst");

        for (int k = 0; k < 600; k++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0: in_a = 16'h8000;
                1: in_a = 16'h7FFF;
                2: in_a = 16'h0080;
                3: in_a = 16'h007F;
                4: in_a = 16'hFFFF;
                default: in_a = 16'($urandom);
            endcase
            out_ready = $urandom_range(0, 3) != 0;
            clr_sticky = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 99) == 0;
            step;
        end
        reset = 0;
        in_valid = 0;
        clr_sticky = 0;
        out_ready = 1;
        step;
        step;
        step;
        chk("drain16", ov16, 0);
        chk("drain8", ov8, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
